// File: rtl/mul_sequencer_pkg.sv
// Shared types, widths and helpers for the sequential MUL/IMUL execution stage.
package mul_sequencer_pkg;

  localparam int unsigned OP_W       = 16;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BYTE_RES_W = 16;
  localparam int unsigned RES_W      = 32;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned SHIFT_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PP   = 2'd1,
    ST_SGN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Left shift applied to the partial product of each byte pair.
  function automatic logic [SHIFT_W-1:0] pp_shift(input logic [IDX_W-1:0] idx);
    case (idx)
      2'd0:    return SHIFT_W'(0);
      2'd3:    return SHIFT_W'(16);
      default: return SHIFT_W'(8);
    endcase
  endfunction

endpackage

// File: rtl/mul_sequencer_multiplier.sv
// Combinational 8x8 unsigned array multiplier fed one byte pair per cycle.
module mul_sequencer_multiplier (
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] Mult
);

  assign Mult = 16'(A) * 16'(B);

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle 8086 MUL/IMUL stage: byte-pair partial products, sign fix-up, CF/OF.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        word,
  input  logic        is_signed,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        cf,
  output logic        of
);

  state_t state_q, state_d;

  logic [OP_W-1:0]  mag_a_q, mag_b_q;
  logic             neg_q, sgn_q, word_q;
  logic [IDX_W-1:0] pp_idx_q, pp_last_q;
  logic [RES_W-1:0] acc_q;
  logic             busy_d, done_d;

  logic             signed_c;
  logic [OP_W-1:0]  opnd_a_c, opnd_b_c, mag_a_c, mag_b_c;
  logic             neg_a_c, neg_b_c;
  logic [7:0]       mul_a_c, mul_b_c;
  logic [15:0]      mul_p_c;
  logic [RES_W-1:0] acc_sum_c, prod_c;
  logic             flag_c;

  // Operand magnitudes; byte operands are sign- or zero-extended to 16 bits first.
  assign signed_c = is_signed & SIGNED_EN;
  assign neg_a_c  = signed_c & (word ? op_a[15] : op_a[7]);
  assign neg_b_c  = signed_c & (word ? op_b[15] : op_b[7]);
  assign opnd_a_c = word ? op_a : {{BYTE_W{signed_c & op_a[7]}}, op_a[7:0]};
  assign opnd_b_c = word ? op_b : {{BYTE_W{signed_c & op_b[7]}}, op_b[7:0]};
  assign mag_a_c  = neg_a_c ? OP_W'(-opnd_a_c) : opnd_a_c;
  assign mag_b_c  = neg_b_c ? OP_W'(-opnd_b_c) : opnd_b_c;

  // Byte pair order: lo*lo, lo*hi, hi*lo, hi*hi.
  assign mul_a_c = pp_idx_q[1] ? mag_a_q[15:8] : mag_a_q[7:0];
  assign mul_b_c = pp_idx_q[0] ? mag_b_q[15:8] : mag_b_q[7:0];

  mul_sequencer_multiplier u_mult (
    .A    (mul_a_c),
    .B    (mul_b_c),
    .Mult (mul_p_c)
  );

  assign acc_sum_c = acc_q + (RES_W'(mul_p_c) << pp_shift(pp_idx_q));
  assign prod_c    = neg_q ? RES_W'(-acc_q) : acc_q;

  // CF/OF: upper half is not a plain zero/sign extension of the lower half.
  always_comb begin
    flag_c = 1'b0;
    if (word_q) begin
      flag_c = sgn_q ? (prod_c[31:16] != {16{prod_c[15]}}) : (prod_c[31:16] != 16'h0000);
    end else begin
      flag_c = sgn_q ? (prod_c[15:8] != {8{prod_c[7]}}) : (prod_c[15:8] != 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_PP;
      ST_PP:   if (pp_idx_q == pp_last_q) state_d = ST_SGN;
      ST_SGN:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_PP) || (state_d == ST_SGN);
    done_d = (state_d == ST_DONE);
  end

  // Operand capture, accumulation and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_q     <= 1'b0;
      sgn_q     <= 1'b0;
      word_q    <= 1'b0;
      pp_idx_q  <= '0;
      pp_last_q <= '0;
      acc_q     <= '0;
      result    <= '0;
      cf        <= 1'b0;
      of        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mag_a_q   <= mag_a_c;
            mag_b_q   <= mag_b_c;
            neg_q     <= neg_a_c ^ neg_b_c;
            sgn_q     <= signed_c;
            word_q    <= word;
            pp_idx_q  <= '0;
            pp_last_q <= word ? IDX_W'(3) : IDX_W'(0);
            acc_q     <= '0;
          end
        end
        ST_PP: begin
          acc_q    <= acc_sum_c;
          pp_idx_q <= pp_idx_q + IDX_W'(1);
        end
        ST_SGN: begin
          result <= word_q ? prod_c : {16'h0000, prod_c[BYTE_RES_W-1:0]};
          cf     <= flag_c;
          of     <= flag_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized scoreboard bench for mul_sequencer against an arithmetic reference model.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, word, is_signed;
  logic [15:0] op_a, op_b;
  logic        busy, done, cf, of;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    logic        flag;
    int          lat;
    int          busy_n;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   busy_run = 0;

  mul_sequencer #(.SIGNED_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .word      (word),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cf        (cf),
    .of        (of)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Product from plain integer arithmetic; flags from the representable range.
  function automatic exp_t model(input bit w, input bit s, input logic [15:0] a,
                                 input logic [15:0] b);
    exp_t   e;
    longint av, bv, p;
    if (w) begin
      av = s ? longint'($signed(a)) : longint'(a);
      bv = s ? longint'($signed(b)) : longint'(b);
    end else begin
      av = s ? longint'($signed(a[7:0])) : longint'(a[7:0]);
      bv = s ? longint'($signed(b[7:0])) : longint'(b[7:0]);
    end
    p = av * bv;
    if (w) begin
      e.res  = 32'(p);
      e.flag = s ? (p < -32768 || p > 32767) : (p > 65535);
    end else begin
      e.res  = {16'h0000, 16'(p)};
      e.flag = s ? (p < -128 || p > 127) : (p > 255);
    end
    e.lat     = w ? 5 : 2;
    e.busy_n  = w ? 5 : 2;
    e.acc_cyc = 0;
    return e;
  endfunction

  // Monitor: every done pops one expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual result=%h required no done", result);
        end else begin
          mon_e = sb.pop_front();
          check("result", result, mon_e.res);
          check("cf", 32'(cf), 32'(mon_e.flag));
          check("of", 32'(of), 32'(mon_e.flag));
          check("latency", 32'(cyc - mon_e.acc_cyc), 32'(mon_e.lat));
          check("busy_cycles", 32'(busy_run), 32'(mon_e.busy_n));
        end
        busy_run = 0;
      end
    end
  end

  task automatic run_op(input bit w, input bit s, input logic [15:0] a, input logic [15:0] b,
                        input bit spur);
    exp_t e;
    bit   seen;
    @(negedge clk);
    word = w; is_signed = s; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    e = model(w, s, a, b);
    e.acc_cyc = cyc;
    sb.push_back(e);
    start = 1'b0;
    op_a = 16'($urandom); op_b = 16'($urandom);
    word = 1'($urandom); is_signed = 1'($urandom);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen  = done;
      start = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      if (spur) begin
        op_a = 16'($urandom); op_b = 16'($urandom);
        word = 1'($urandom); is_signed = 1'($urandom);
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no done required=done within 20 cycles");
      sb.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; start = 1'b0; word = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_result", result, 32'h0);
    check("rst_cf", 32'(cf), 32'(0));
    check("rst_of", 32'(of), 32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 1'b0, 16'h00FF, 16'h00FF, 1'b0);
    run_op(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    run_op(1'b1, 1'b1, 16'h8000, 16'hFFFF, 1'b0);
    run_op(1'b1, 1'b1, 16'h0003, 16'hFFFE, 1'b0);
    run_op(1'b0, 1'b1, 16'h00FE, 16'h0003, 1'b0);
    run_op(1'b0, 1'b1, 16'h0080, 16'h0080, 1'b0);
    run_op(1'b0, 1'b1, 16'hA5FE, 16'h5A03, 1'b0);

    // Ignored starts while busy and in the done cycle, then an immediate restart.
    run_op(1'b1, 1'b1, 16'h1234, 16'hF00D, 1'b1);
    run_op(1'b1, 1'b0, 16'h0012, 16'h0034, 1'b0);
    check("restart_result", result, 32'h000003A8);

    // Asynchronous reset in the third partial-product cycle of a word op.
    @(negedge clk);
    word = 1'b1; is_signed = 1'b0; op_a = 16'hBEEF; op_b = 16'hCAFE; start = 1'b1;
    @(posedge clk); #1;
    e = model(1'b1, 1'b0, 16'hBEEF, 16'hCAFE);
    e.acc_cyc = cyc;
    sb.push_back(e);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_result", result, 32'h0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_done_after_abort", 32'(done), 32'(0));
    end
    run_op(1'b1, 1'b0, 16'hBEEF, 16'hCAFE, 1'b0);

    for (int i = 0; i < 60; i++) begin
      run_op(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    run_op(1'b1, 1'b1, 16'h8000, 16'h8000, 1'b0);
    run_op(1'b0, 1'b0, 16'h0000, 16'h00FF, 1'b0);
    idle(5);
    check("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
